// File: rtl/bus_arbiter.sv
// bus_arbiter: three-master fixed-priority arbiter for a shared 16-bit address / 8-bit data bus.
// Priority VGA (bit0) > UART (bit1) > CPU (bit2); no preemption; one TURN cycle between owners.
// The owner's o_cs/o_we/o_addr/o_dat are muxed combinationally onto the bus while in OWN.
// Optional feature macro: ARB_TIMEOUT_EN adds a wait-state watchdog that force-acks and
// releases the bus after TIMEOUT_CYCLES wait cycles; without it o_timeout is tied to 0.
module bus_arbiter #(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic        i_clk,
    input  logic        i_reset,
    input  logic [2:0]  i_cs,
    input  logic [2:0]  i_we,
    input  logic [47:0] i_addr,
    input  logic [23:0] i_dat,
    input  logic        i_ack,
    output logic [2:0]  o_ack,
    output logic [2:0]  o_grant,
    output logic        o_cs,
    output logic        o_we,
    output logic [15:0] o_addr,
    output logic [7:0]  o_dat,
    output logic        o_timeout
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_OWN  = 2'd1,
        ST_TURN = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [2:0]  grant_q, grant_d;
    logic [1:0]  owner_s;
    logic        own_s;
    logic        sel_cs_s;
    logic        sel_we_s;
    logic [15:0] sel_addr_s;
    logic [7:0]  sel_dat_s;
    logic        timeout_s;
    logic        ack_bit_s;

    assign own_s = (state_q == ST_OWN);

    // Decode the one-hot grant into the owner's index.
    always_comb begin
        owner_s = 2'd0;
        case (grant_q)
            3'b001:  owner_s = 2'd0;
            3'b010:  owner_s = 2'd1;
            3'b100:  owner_s = 2'd2;
            default: owner_s = 2'd0;
        endcase
    end

    // Select the owner's request fields from the packed per-master inputs.
    always_comb begin
        sel_cs_s   = 1'b0;
        sel_we_s   = 1'b0;
        sel_addr_s = 16'h0000;
        sel_dat_s  = 8'h00;
        case (owner_s)
            2'd0: begin
                sel_cs_s   = i_cs[0];
                sel_we_s   = i_we[0];
                sel_addr_s = i_addr[15:0];
                sel_dat_s  = i_dat[7:0];
            end
            2'd1: begin
                sel_cs_s   = i_cs[1];
                sel_we_s   = i_we[1];
                sel_addr_s = i_addr[31:16];
                sel_dat_s  = i_dat[15:8];
            end
            2'd2: begin
                sel_cs_s   = i_cs[2];
                sel_we_s   = i_we[2];
                sel_addr_s = i_addr[47:32];
                sel_dat_s  = i_dat[23:16];
            end
            default: begin
                sel_cs_s   = 1'b0;
                sel_we_s   = 1'b0;
                sel_addr_s = 16'h0000;
                sel_dat_s  = 8'h00;
            end
        endcase
    end

`ifdef ARB_TIMEOUT_EN
    localparam logic [15:0] TIMEOUT_W = 16'(TIMEOUT_CYCLES);
    logic [15:0] wait_q, wait_d;

    assign timeout_s = own_s && (wait_q == TIMEOUT_W);

    // Wait counter: zero outside OWN (so it is clear on entry), cleared by a slave ack.
    always_comb begin
        wait_d = 16'h0000;
        if (own_s) begin
            if (i_ack) begin
                wait_d = 16'h0000;
            end else begin
                wait_d = wait_q + 16'd1;
            end
        end else begin
            wait_d = 16'h0000;
        end
    end

    // Wait counter register.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            wait_q <= 16'h0000;
        end else begin
            wait_q <= wait_d;
        end
    end
`else
    assign timeout_s = 1'b0;
`endif

    // Next-state and grant logic: fixed priority in IDLE, hold until owner drops, one TURN cycle.
    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        case (state_q)
            ST_IDLE: begin
                if (i_cs != 3'b000) begin
                    state_d = ST_OWN;
                    if (i_cs[0]) begin
                        grant_d = 3'b001;
                    end else if (i_cs[1]) begin
                        grant_d = 3'b010;
                    end else begin
                        grant_d = 3'b100;
                    end
                end else begin
                    state_d = ST_IDLE;
                    grant_d = 3'b000;
                end
            end
            ST_OWN: begin
                if (timeout_s || !sel_cs_s) begin
                    state_d = ST_TURN;
                    grant_d = 3'b000;
                end else begin
                    state_d = ST_OWN;
                    grant_d = grant_q;
                end
            end
            ST_TURN: begin
                state_d = ST_IDLE;
                grant_d = 3'b000;
            end
            default: begin
                state_d = ST_IDLE;
                grant_d = 3'b000;
            end
        endcase
    end

    // State and grant registers.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            state_q <= ST_IDLE;
            grant_q <= 3'b000;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
        end
    end

    // A forced termination acks the owner even without a slave ack.
    assign ack_bit_s = own_s & ((i_ack & sel_cs_s) | timeout_s);

    assign o_grant   = grant_q;
    assign o_ack     = grant_q & {3{ack_bit_s}};
    assign o_cs      = own_s & sel_cs_s;
    assign o_we      = own_s & sel_we_s;
    assign o_addr    = own_s ? sel_addr_s : 16'h0000;
    assign o_dat     = own_s ? sel_dat_s : 8'h00;
    assign o_timeout = timeout_s;

endmodule

// File: doc/bus_arbiter.md
BUS_ARBITER -- requirements
Module: bus_arbiter

Interface
REQ-001 Parameter TIMEOUT_CYCLES, default 255: wait-state limit per granted transaction (1..65535).
REQ-002 i_clk  input  1  system clock; all state updates on rising edge.
REQ-003 i_reset  input  1  asynchronous, active-high reset.
REQ-004 i_cs  input  3  per-master request; bit0 = VGA, bit1 = UART master, bit2 = CPU.
REQ-005 i_we  input  3  per-master write enable.
REQ-006 i_addr  input  48  per-master address; master n uses bits [16n+15:16n].
REQ-007 i_dat  input  24  per-master write data; master n uses bits [8n+7:8n].
REQ-008 o_ack  output  3  per-master acknowledge.
REQ-009 o_grant  output  3  registered one-hot grant; all-zero when the bus is not owned.
REQ-010 o_cs, o_we  output  1 each  shared-bus chip select and write enable.
REQ-011 o_addr  output  16  shared-bus address.
REQ-012 o_dat  output  8  shared-bus write data.
REQ-013 i_ack  input  1  shared-bus slave acknowledge.
REQ-014 o_timeout  output  1  one-cycle pulse on a forced termination; constant 0 when the feature is compiled out.

Function
REQ-015 The FSM SHALL have exactly three states: IDLE, OWN and TURN.
REQ-016 IDLE: if any i_cs bit is set, the block SHALL grant the lowest-index requester (fixed priority VGA > UART > CPU), load o_grant and enter OWN on the next edge.
REQ-017 IDLE with no i_cs bit set: the block SHALL stay in IDLE.
REQ-018 OWN: o_cs SHALL equal i_cs[owner], and o_we, o_addr and o_dat SHALL mux combinationally from the owner's inputs.
REQ-019 Outside OWN: o_cs, o_we, o_addr and o_dat SHALL be 0.
REQ-020 o_ack[owner] SHALL equal i_ack & o_cs in OWN; all other o_ack bits SHALL be 0 at all times.
REQ-021 The owner SHALL keep the grant, even if a higher-priority master requests, until its i_cs deasserts (no preemption).
REQ-022 OWN with i_cs[owner]=0 at an edge: the block SHALL enter TURN and clear o_grant.
REQ-023 TURN SHALL last exactly one cycle with the bus idle, then return to IDLE.
REQ-024 Latency: a request arriving at an idle bus SHALL see o_cs at cycle +1.
REQ-025 Latency: back-to-back grants to different masters SHALL be separated by at least two bus-idle cycles (TURN, then IDLE).
REQ-026 Simultaneous requests in IDLE SHALL resolve strictly by priority.
REQ-027 A losing master SHALL keep its request pending, with no o_ack, until it is granted.
REQ-028 A request deasserted by a non-owner SHALL be dropped with no side effects.

Reset
REQ-029 On i_reset=1, the block SHALL asynchronously set the state to IDLE.
REQ-030 On i_reset=1, o_grant, o_ack, o_cs, o_we, o_addr, o_dat and o_timeout SHALL be 0, and the wait counter SHALL be 0.
REQ-031 Reset asserted mid-transaction SHALL abort the transaction without an o_ack pulse.
REQ-032 The first grant after reset release SHALL occur no earlier than the first edge on which i_reset is sampled low.

Configuration
REQ-033 The macro ARB_TIMEOUT_EN SHALL control the wait-state watchdog.
REQ-034 With ARB_TIMEOUT_EN defined, a 16-bit counter SHALL clear on entry to OWN and whenever i_ack=1, and SHALL otherwise increment each OWN cycle.
REQ-035 With ARB_TIMEOUT_EN defined, when the counter equals TIMEOUT_CYCLES the block SHALL pulse o_ack[owner] and o_timeout for one cycle and enter TURN, regardless of i_cs[owner].
REQ-036 With ARB_TIMEOUT_EN undefined, no counter SHALL be built, o_timeout SHALL be tied to 0, and OWN SHALL wait indefinitely.

Verification
REQ-037 CPU-only request, i_ack asserted 3 cycles after o_cs -> o_grant=3'b100 at cycle +1, o_ack[2] coincides with i_ack, and o_addr/o_dat equal the CPU's values.
REQ-038 VGA, UART and CPU request in the same cycle -> order VGA, then UART, then CPU, with a 2-cycle idle gap between each grant.
REQ-039 CPU owns the bus while VGA requests -> CPU keeps the grant until it drops i_cs; VGA is granted 2 cycles later.
REQ-040 UART owns the bus and i_ack stays 0, with ARB_TIMEOUT_EN and TIMEOUT_CYCLES=4 -> o_ack[1] and o_timeout pulse at the 4th wait cycle and the bus then releases; without the macro, o_grant stays 3'b010.
REQ-041 i_reset pulsed during OWN with i_ack pending -> all outputs are 0 immediately and no o_ack pulse occurs.
